// File: rtl/stage4_n_type_ctrl_seq_pkg.sv
// ---------------------------------------------------------------------------
// stage4_n_type_ctrl_seq_pkg
// Shared definitions for the stage-4 N-type select sequencer: message and
// select widths, node-type codes, the default-select code N_type_X, the
// default message value and the sequencer FSM state encoding.
// No ports (package).
// ---------------------------------------------------------------------------
package stage4_n_type_ctrl_seq_pkg;

    localparam int MAX_MESSAGE_BITS     = 8;
    localparam int N_type_control_width = 3;

    typedef logic [N_type_control_width-1:0] ntype_t;

    localparam ntype_t N_type_L = 3'd0;
    localparam ntype_t N_type_M = 3'd1;
    localparam ntype_t N_type_N = 3'd2;
    localparam ntype_t N_type_R = 3'd3;
    localparam ntype_t N_type_S = 3'd4;
    // Matches none of the node codes, so the select stage falls through to
    // defaut_message on any lane carrying it.
    localparam ntype_t N_type_X = 3'd7;

    localparam logic [MAX_MESSAGE_BITS-1:0] defaut_message = '0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    function automatic logic type_is_legal(input ntype_t t);
        return (t == N_type_L) || (t == N_type_M) || (t == N_type_N) ||
               (t == N_type_R) || (t == N_type_S);
    endfunction

endpackage

// File: rtl/stage4_n_type_ctrl_seq_if.sv
// ---------------------------------------------------------------------------
// stage4_n_type_ctrl_seq_if
// Bundles the descriptor stream (desc_*) from the schedule front end and the
// per-lane select beat (ctrl_*, lane_en, N_type_control_m1..m3) towards the
// stage-4 message select.
//   slave  : the sequencer side (consumes descriptors, produces beats)
//   master : the environment side (produces descriptors, consumes beats)
// ---------------------------------------------------------------------------
interface stage4_n_type_ctrl_seq_if #(
    parameter int LEN_W = 8
);
    // descriptor stream
    logic                                   desc_valid;
    logic                                   desc_ready;
    stage4_n_type_ctrl_seq_pkg::ntype_t     desc_type;
    logic [LEN_W-1:0]                       desc_len;
    logic                                   desc_last;
    // select beat
    logic                                   out_ready;
    logic                                   ctrl_valid;
    stage4_n_type_ctrl_seq_pkg::ntype_t     N_type_control_m1;
    stage4_n_type_ctrl_seq_pkg::ntype_t     N_type_control_m2;
    stage4_n_type_ctrl_seq_pkg::ntype_t     N_type_control_m3;
    logic [2:0]                             lane_en;
    logic                                   ctrl_last;

    modport slave (
        input  desc_valid, desc_type, desc_len, desc_last, out_ready,
        output desc_ready, ctrl_valid, N_type_control_m1, N_type_control_m2,
               N_type_control_m3, lane_en, ctrl_last
    );

    modport master (
        output desc_valid, desc_type, desc_len, desc_last, out_ready,
        input  desc_ready, ctrl_valid, N_type_control_m1, N_type_control_m2,
               N_type_control_m3, lane_en, ctrl_last
    );

endinterface

// File: rtl/stage4_desc_fifo.sv
// ---------------------------------------------------------------------------
// stage4_desc_fifo
// Synchronous show-ahead FIFO buffering node descriptors.
//   clk, rst_n       : clock, asynchronous active-low reset (flushes pointers)
//   wr_en, wr_data   : push request and data (ignored while full)
//   rd_en, rd_data   : pop request (ignored while empty), head entry
//   full, empty      : occupancy flags
// ---------------------------------------------------------------------------
module stage4_desc_fifo #(
    parameter int W     = 12,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    // One extra pointer bit separates full from empty when the indices match.
    logic [AW:0]  wr_ptr, rd_ptr;
    logic         push, pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push  = wr_en && !full;
    assign pop   = rd_en && !empty;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/stage4_n_type_ctrl_seq.sv
// ---------------------------------------------------------------------------
// stage4_n_type_ctrl_seq
// Turns a frame's node schedule (type + message count per descriptor) into
// three-lane N-type select beats for the stage-4 message select.
//   clk, rst_n   : clock, asynchronous active-low reset
//   frame_start  : starts a frame (only acted on in IDLE)
//   bus (slave)  : descriptor stream in, select beats out
//   frame_done   : one-cycle pulse after the frame's last beat is taken
//   busy         : sequencer not idle
//   err_type     : sticky illegal-type flag, cleared by frame_start
// ---------------------------------------------------------------------------
module stage4_n_type_ctrl_seq
    import stage4_n_type_ctrl_seq_pkg::*;
#(
    parameter int LEN_W      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          frame_start,
    stage4_n_type_ctrl_seq_if.slave       bus,
    output logic                          frame_done,
    output logic                          busy,
    output logic                          err_type
);
    localparam int FW = N_type_control_width + LEN_W + 1;

    seq_state_t        state, state_n;
    logic [LEN_W-1:0]  rem, rem_n, rem_after;
    ntype_t            type_q, type_n;
    logic              last_q, last_n;
    logic              err_n, valid_n, clast_n, done_n;
    logic [2:0]        lane_n;
    ntype_t            m1_n, m2_n, m3_n;
    logic              take, pop;

    logic [FW-1:0]     fifo_head;
    logic              fifo_full, fifo_empty;
    ntype_t            fifo_type;
    logic [LEN_W-1:0]  fifo_len;
    logic              fifo_last;

    stage4_desc_fifo #(.W(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (bus.desc_valid),
        .wr_data ({bus.desc_type, bus.desc_len, bus.desc_last}),
        .rd_en   (pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign {fifo_type, fifo_len, fifo_last} = fifo_head;
    assign bus.desc_ready = !fifo_full;
    assign busy           = (state != IDLE);
    assign rem_after      = (rem > LEN_W'(3)) ? rem - LEN_W'(3) : '0;

    function automatic logic [2:0] lane_mask(input logic [LEN_W-1:0] r);
        if (r >= LEN_W'(3))      return 3'b111;
        else if (r == LEN_W'(2)) return 3'b011;
        else if (r == LEN_W'(1)) return 3'b001;
        else                     return 3'b000;
    endfunction

    always_comb begin
        state_n = state;
        rem_n   = rem;
        type_n  = type_q;
        last_n  = last_q;
        err_n   = err_type;
        valid_n = bus.ctrl_valid;
        take    = 1'b0;
        pop     = 1'b0;

        case (state)
            IDLE: begin
                if (frame_start) begin
                    state_n = FETCH;
                    err_n   = 1'b0;
                end
            end
            FETCH: begin
                if (!fifo_empty) take = 1'b1;
            end
            ISSUE: begin
                if (bus.ctrl_valid && bus.out_ready) begin
                    rem_n = rem_after;
                    if (rem_after == '0) begin
                        if (last_q) begin
                            state_n = DONE;
                            valid_n = 1'b0;
                        end else if (!fifo_empty) begin
                            // Reload straight from the FIFO so node boundaries
                            // cost no idle cycle.
                            take = 1'b1;
                        end else begin
                            state_n = FETCH;
                            valid_n = 1'b0;
                        end
                    end
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase

        if (take) begin
            pop    = 1'b1;
            last_n = fifo_last;
            if (fifo_len == '0) begin
                valid_n = 1'b0;
                rem_n   = '0;
                state_n = fifo_last ? DONE : FETCH;
            end else begin
                rem_n   = fifo_len;
                type_n  = type_is_legal(fifo_type) ? fifo_type : N_type_X;
                err_n   = err_n | !type_is_legal(fifo_type);
                valid_n = 1'b1;
                state_n = ISSUE;
            end
        end

        // Beat outputs are a function of the next remaining count, so a
        // stalled beat (rem unchanged) re-registers identical values.
        lane_n  = valid_n ? lane_mask(rem_n) : 3'b000;
        m1_n    = lane_n[0] ? type_n : N_type_X;
        m2_n    = lane_n[1] ? type_n : N_type_X;
        m3_n    = lane_n[2] ? type_n : N_type_X;
        clast_n = valid_n && last_n && (rem_n <= LEN_W'(3));
        done_n  = (state_n == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                 <= IDLE;
            rem                   <= '0;
            type_q                <= N_type_X;
            last_q                <= 1'b0;
            err_type              <= 1'b0;
            frame_done            <= 1'b0;
            bus.ctrl_valid        <= 1'b0;
            bus.lane_en           <= 3'b000;
            bus.ctrl_last         <= 1'b0;
            bus.N_type_control_m1 <= N_type_X;
            bus.N_type_control_m2 <= N_type_X;
            bus.N_type_control_m3 <= N_type_X;
        end else begin
            state                 <= state_n;
            rem                   <= rem_n;
            type_q                <= type_n;
            last_q                <= last_n;
            err_type              <= err_n;
            frame_done            <= done_n;
            bus.ctrl_valid        <= valid_n;
            bus.lane_en           <= lane_n;
            bus.ctrl_last         <= clast_n;
            bus.N_type_control_m1 <= m1_n;
            bus.N_type_control_m2 <= m2_n;
            bus.N_type_control_m3 <= m3_n;
        end
    end

endmodule

// File: tb/tb_stage4_n_type_ctrl_seq.sv
// ---------------------------------------------------------------------------
// tb_stage4_n_type_ctrl_seq
// Directed bench for the stage-4 N-type select sequencer.
// ---------------------------------------------------------------------------
module tb_stage4_n_type_ctrl_seq;
    import stage4_n_type_ctrl_seq_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic frame_start = 1'b0;
    logic frame_done, busy, err_type;

    int errors = 0;
    int checks = 0;

    stage4_n_type_ctrl_seq_if #(.LEN_W(8)) bus ();

    stage4_n_type_ctrl_seq #(.LEN_W(8), .FIFO_DEPTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .bus         (bus.slave),
        .frame_done  (frame_done),
        .busy        (busy),
        .err_type    (err_type)
    );

    always #5 clk = ~clk;

    // accepted beats of the most recent frame
    logic [2:0] b_lane [16];
    logic [8:0] b_m    [16];
    logic       b_last [16];
    int         b_cyc  [16];
    int         nb;
    int         done_cyc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input ntype_t t, input logic [7:0] l, input logic last);
        bus.desc_valid = 1'b1;
        bus.desc_type  = t;
        bus.desc_len   = l;
        bus.desc_last  = last;
        step();
        bus.desc_valid = 1'b0;
    endtask

    // Pulses frame_start, then collects accepted beats until frame_done.
    // out_ready is held low for cycles [stall_from, stall_from+stall_len).
    task automatic run_frame(input int stall_from, input int stall_len, input int max_cyc);
        logic [2:0] pl;
        logic [8:0] pm;
        logic       pc;
        logic       prev_stall;
        nb = 0;
        done_cyc = -1;
        prev_stall = 1'b0;
        pl = '0;
        pm = '0;
        pc = 1'b0;
        frame_start = 1'b1;
        for (int cyc = 1; cyc <= max_cyc; cyc++) begin
            step();
            frame_start = 1'b0;
            bus.out_ready = !(cyc >= stall_from && cyc < stall_from + stall_len);
            if (prev_stall) begin
                chk("hold_valid", bus.ctrl_valid, 1);
                chk("hold_lane", bus.lane_en, pl);
                chk("hold_m", {bus.N_type_control_m3, bus.N_type_control_m2, bus.N_type_control_m1}, pm);
                chk("hold_last", bus.ctrl_last, pc);
            end
            prev_stall = bus.ctrl_valid && !bus.out_ready;
            pl = bus.lane_en;
            pm = {bus.N_type_control_m3, bus.N_type_control_m2, bus.N_type_control_m1};
            pc = bus.ctrl_last;
            if (bus.ctrl_valid && bus.out_ready && nb < 16) begin
                b_lane[nb] = bus.lane_en;
                b_m[nb]    = pm;
                b_last[nb] = bus.ctrl_last;
                b_cyc[nb]  = cyc;
                nb++;
            end
            if (frame_done) begin
                done_cyc = cyc;
                break;
            end
        end
        if (done_cyc < 0) chk("frame_timeout", 0, 1);
        bus.out_ready = 1'b1;
    endtask

    task automatic chk_beat(input int i, input logic [2:0] lane, input logic [8:0] m,
                            input logic last, input int cyc);
        chk($sformatf("beat%0d_lane", i), b_lane[i], lane);
        chk($sformatf("beat%0d_m", i), b_m[i], m);
        chk($sformatf("beat%0d_last", i), b_last[i], last);
        chk($sformatf("beat%0d_cyc", i), b_cyc[i], cyc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.desc_valid = 1'b0;
        bus.desc_type  = '0;
        bus.desc_len   = '0;
        bus.desc_last  = 1'b0;
        bus.out_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        step();

        // reset state
        chk("rst_valid", bus.ctrl_valid, 0);
        chk("rst_lane", bus.lane_en, 0);
        chk("rst_m1", bus.N_type_control_m1, N_type_X);
        chk("rst_m2", bus.N_type_control_m2, N_type_X);
        chk("rst_m3", bus.N_type_control_m3, N_type_X);
        chk("rst_last", bus.ctrl_last, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err_type, 0);
        chk("rst_ready", bus.desc_ready, 1);

        // single node L/7, last
        push(N_type_L, 8'd7, 1'b1);
        run_frame(0, 0, 20);
        chk("t1_nbeats", nb, 3);
        chk_beat(0, 3'b111, {N_type_L, N_type_L, N_type_L}, 1'b0, 2);
        chk_beat(1, 3'b111, {N_type_L, N_type_L, N_type_L}, 1'b0, 3);
        chk_beat(2, 3'b001, {N_type_X, N_type_X, N_type_L}, 1'b1, 4);
        chk("t1_done_cyc", done_cyc, 5);
        step();
        chk("t1_done_pulse", frame_done, 0);
        chk("t1_idle", busy, 0);

        // M/3 then S/2 (last), back to back
        push(N_type_M, 8'd3, 1'b0);
        push(N_type_S, 8'd2, 1'b1);
        run_frame(0, 0, 20);
        chk("t2_nbeats", nb, 2);
        chk_beat(0, 3'b111, {N_type_M, N_type_M, N_type_M}, 1'b0, 2);
        chk_beat(1, 3'b011, {N_type_X, N_type_S, N_type_S}, 1'b1, 3);
        chk("t2_done_cyc", done_cyc, 4);

        // R/9 with a 4-cycle stall on the second beat
        push(N_type_R, 8'd9, 1'b1);
        run_frame(3, 4, 30);
        chk("t3_nbeats", nb, 3);
        chk_beat(0, 3'b111, {N_type_R, N_type_R, N_type_R}, 1'b0, 2);
        chk_beat(1, 3'b111, {N_type_R, N_type_R, N_type_R}, 1'b0, 7);
        chk_beat(2, 3'b111, {N_type_R, N_type_R, N_type_R}, 1'b1, 8);
        chk("t3_done_cyc", done_cyc, 9);

        // zero-length node, then N/1 (last)
        push(N_type_N, 8'd0, 1'b0);
        push(N_type_N, 8'd1, 1'b1);
        run_frame(0, 0, 20);
        chk("t4_nbeats", nb, 1);
        chk_beat(0, 3'b001, {N_type_X, N_type_X, N_type_N}, 1'b1, 3);
        chk("t4_done_cyc", done_cyc, 4);
        chk("t4_err", err_type, 0);

        // illegal type code 5, len 4
        push(3'd5, 8'd4, 1'b1);
        run_frame(0, 0, 20);
        chk("t5_nbeats", nb, 2);
        chk_beat(0, 3'b111, {N_type_X, N_type_X, N_type_X}, 1'b0, 2);
        chk_beat(1, 3'b001, {N_type_X, N_type_X, N_type_X}, 1'b1, 3);
        chk("t5_done_cyc", done_cyc, 4);
        chk("t5_err", err_type, 1);
        step();
        chk("t5_err_sticky", err_type, 1);

        // fill the FIFO in IDLE, then reset mid-frame
        for (int i = 0; i < 5; i++) begin
            push(N_type_L, 8'd6, 1'b0);
            chk($sformatf("t6_ready_%0d", i), bus.desc_ready, (i < 3) ? 1 : 0);
        end
        chk("t6_err_before_start", err_type, 1);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        chk("t6_err_cleared", err_type, 0);
        chk("t6_busy", busy, 1);
        step();
        chk("t6_beat_valid", bus.ctrl_valid, 1);
        chk("t6_beat_lane", bus.lane_en, 3'b111);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", bus.ctrl_valid, 0);
        chk("t6_rst_lane", bus.lane_en, 0);
        chk("t6_rst_m", {bus.N_type_control_m3, bus.N_type_control_m2, bus.N_type_control_m1},
            {N_type_X, N_type_X, N_type_X});
        chk("t6_rst_last", bus.ctrl_last, 0);
        chk("t6_rst_done", frame_done, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_err", err_type, 0);
        chk("t6_rst_ready", bus.desc_ready, 1);
        #1 rst_n = 1'b1;
        step();
        // FIFO must be empty: a new frame sits in FETCH with no beat
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("t6_flushed_%0d", i), bus.ctrl_valid, 0);
        end
        chk("t6_fetch_busy", busy, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
